// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtract-with-borrow unit. Operands are captured on START and
//   the difference D = A - B - BI is produced one bit per clock, LSB first.
//   When the last bit is done, D and BO are updated together and DONE pulses
//   for one cycle. D and BO then hold until the next completion.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//
// Ports
//   CK         clock; all state changes happen on the rising edge
//   RST        synchronous active-high reset
//   START      request; sampled only while BUSY=0
//   A, B, BI   minuend, subtrahend, borrow-in; sampled together with START
//   BUSY       high while a subtraction is in progress
//   DONE       one-cycle completion pulse
//   D          difference modulo 2^WIDTH
//   BO         borrow-out (1 iff A < B + BI, unsigned)
//   DBG_STATE  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a request is taken on a rising edge where START=1 and the unit
// is idle (BUSY=0, which includes the DONE cycle). START while BUSY=1 is
// ignored. DONE rises WIDTH edges after the accepting edge.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             DBG_STATE
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_rd_next;

    // One full-subtractor stage on the current LSBs.
    assign w_a  = r_ra[0];
    assign w_b  = r_rb[0];
    assign w_d  = w_a ^ w_b ^ r_br;
    assign w_bo = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

    // New bit enters at the MSB; after WIDTH shifts the first bit sits at LSB.
    generate
        if (WIDTH == 1) begin : g_rd_one
            assign w_rd_next = w_d;
        end else begin : g_rd_wide
            assign w_rd_next = {w_d, r_rd[WIDTH-1:1]};
        end
    endgenerate

    assign DBG_STATE = r_state;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            D       <= '0;
            BO      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_ra    <= A;
                        r_rb    <= B;
                        r_br    <= BI;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_rd  <= w_rd_next;
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    // Final bit: publish result directly from the next-value
                    // path so D includes the bit computed on this edge.
                    if (r_cnt == LAST) begin
                        D       <= w_rd_next;
                        BO      <= w_bo;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor: an 8-bit instance for the main
//   operations, reset abort, ignored START and back-to-back requests, and a
//   1-bit instance for the full truth table of the subtractor with borrow.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    // ---------------- clock / reset ----------------
    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic       RST;
    logic       START;
    logic [7:0] A, B;
    logic       BI;
    logic       BUSY, DONE, BO, DBG_STATE;
    logic [7:0] D;

    logic START1, A1, B1, BI1;
    logic BUSY1, DONE1, D1, BO1, DBG_STATE1;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .CK(CK), .RST(RST), .START(START), .A(A), .B(B), .BI(BI),
        .BUSY(BUSY), .DONE(DONE), .D(D), .BO(BO), .DBG_STATE(DBG_STATE)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .CK(CK), .RST(RST), .START(START1), .A(A1), .B(B1), .BI(BI1),
        .BUSY(BUSY1), .DONE(DONE1), .D(D1), .BO(BO1), .DBG_STATE(DBG_STATE1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;
    int t_start  = 0;
    logic both_high = 1'b0;

    // BUSY and DONE must never overlap; sampled away from the edge.
    always @(negedge CK) begin
        if (!RST && BUSY && DONE) both_high = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CK);
        #1;
        ecount++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one edge, then scramble the inputs to
    // show that only the sampled values matter.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
        A = a; B = b; BI = bi; START = 1'b1;
        step();
        t_start = ecount;
        START = 1'b0;
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
        BI = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for DONE and report its distance from the start edge.
    task automatic wait_done(output int lat);
        while (!DONE && (ecount - t_start) < 20) step();
        lat = ecount - t_start;
    endtask

    task automatic finish_check(input string tag, input logic [7:0] exp_d, input logic exp_bo);
        int lat;
        wait_done(lat);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_done"}, DONE, 1'b1);
        check({tag, "_busy_at_done"}, BUSY, 1'b0);
        check({tag, "_d"}, D, exp_d);
        check({tag, "_bo"}, BO, exp_bo);
        step();
        check({tag, "_done_drop"}, DONE, 1'b0);
        check({tag, "_d_hold"}, D, exp_d);
        check({tag, "_bo_hold"}, BO, exp_bo);
    endtask

    // ---------------- stimulus / checks ----------------
    logic [1:0] tt [8];
    logic       seen;
    logic       d_moved;
    int         t_first;
    int         lat;

    initial begin
        // {BO,D} indexed by {a,b,bi}, worked out by hand from a - b - bi.
        tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b10;
        tt[4] = 2'b01; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

        RST = 1'b1; START = 1'b0; A = '0; B = '0; BI = 1'b0;
        START1 = 1'b0; A1 = 1'b0; B1 = 1'b0; BI1 = 1'b0;
        step(); step();
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_d", D, 8'h00);
        check("rst_bo", BO, 1'b0);
        check("rst_state", DBG_STATE, 1'b0);
        RST = 1'b0;
        step();

        // T1: basic subtraction, BUSY for 8 cycles
        start_op(8'h35, 8'h12, 1'b0);
        check("t1_busy", BUSY, 1'b1);
        check("t1_state", DBG_STATE, 1'b1);
        finish_check("t1", 8'h23, 1'b0);

        // T2: underflow, then borrow-in consumed exactly
        start_op(8'h00, 8'h01, 1'b0);
        finish_check("t2a", 8'hFF, 1'b1);
        start_op(8'h10, 8'h0F, 1'b1);
        finish_check("t2b", 8'h00, 1'b0);

        // T3: all ones with borrow-in; START on BUSY cycle 3 must be ignored
        start_op(8'hFF, 8'hFF, 1'b1);
        step();
        A = 8'h01; B = 8'h00; BI = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        check("t3_busy_after_ignored", BUSY, 1'b1);
        finish_check("t3", 8'hFF, 1'b1);
        step();
        check("t3_no_extra_op", BUSY, 1'b0);

        // T4: reset in the middle of a shift aborts without a DONE
        start_op(8'h35, 8'h12, 1'b0);
        step(); step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t4_busy", BUSY, 1'b0);
        check("t4_done", DONE, 1'b0);
        check("t4_d", D, 8'h00);
        check("t4_bo", BO, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (DONE) seen = 1'b1;
        end
        check("t4_no_done", seen, 1'b0);
        start_op(8'h35, 8'h12, 1'b0);
        finish_check("t4_restart", 8'h23, 1'b0);

        // T5: START held high; the second request is taken in the DONE cycle
        A = 8'h80; B = 8'h01; BI = 1'b0; START = 1'b1;
        step();
        t_start = ecount;
        A = 8'h01; B = 8'h80; BI = 1'b0;
        wait_done(lat);
        check("t5a_latency", lat, 8);
        check("t5a_d", D, 8'h7F);
        check("t5a_bo", BO, 1'b0);
        t_first = ecount;
        step();
        START = 1'b0;
        A = 8'h5A; B = 8'hA5;
        check("t5_busy_again", BUSY, 1'b1);
        t_start = ecount;
        d_moved = 1'b0;
        while (!DONE && (ecount - t_start) < 20) begin
            if (D !== 8'h7F || BO !== 1'b0) d_moved = 1'b1;
            step();
        end
        check("t5_d_stable", d_moved, 1'b0);
        check("t5b_gap", ecount - t_first, 9);
        check("t5b_d", D, 8'h81);
        check("t5b_bo", BO, 1'b1);
        step();

        // T6: WIDTH=1 truth table, DONE one edge after START
        for (int i = 0; i < 8; i++) begin
            A1 = i[2]; B1 = i[1]; BI1 = i[0]; START1 = 1'b1;
            step();
            START1 = 1'b0;
            A1 = ~A1; B1 = ~B1; BI1 = ~BI1;
            check($sformatf("t6_busy_%0d", i), BUSY1, 1'b1);
            check($sformatf("t6_early_done_%0d", i), DONE1, 1'b0);
            step();
            check($sformatf("t6_done_%0d", i), DONE1, 1'b1);
            check($sformatf("t6_busy_at_done_%0d", i), BUSY1, 1'b0);
            check($sformatf("t6_result_%0d", i), {BO1, D1}, tt[i]);
            step();
        end

        check("busy_done_overlap", both_high, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
